// File: rtl/ofs_fim_pcie_pkg.sv
// ----------------------------------------------------------------------------
// ofs_fim_pcie_pkg
// Shared definitions for the FIM PCIe TX path:
//   - AVST TX beat types (t_avst_tx per channel, t_avst_txs per beat)
//   - TX arbiter limits and FSM state type
//   - small helpers for scanning a beat (any-valid, valid-clear, packet tracking)
// ----------------------------------------------------------------------------
package ofs_fim_pcie_pkg;

    localparam int TX_ARB_MAX_REQ = 8;

    localparam int NUM_AVST_CH = 2;
    localparam int AVST_HDR_W  = 32;
    localparam int AVST_DATA_W = 64;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} t_tx_arb_state;

    typedef struct packed {
        logic                   valid;
        logic                   sop;
        logic                   eop;
        logic [AVST_HDR_W-1:0]  hdr;
        logic [AVST_DATA_W-1:0] data;
        logic                   vf_active;
    } t_avst_tx;

    typedef t_avst_tx [NUM_AVST_CH-1:0] t_avst_txs;

    // True when any channel of the beat carries a valid TLP fragment.
    function automatic logic tx_any_valid(input t_avst_txs beat);
        logic any_v;
        any_v = 1'b0;
        for (int ch = 0; ch < NUM_AVST_CH; ch++) begin
            any_v = any_v | beat[ch].valid;
        end
        return any_v;
    endfunction

    // Same beat with every valid dropped; payload bits are left untouched.
    function automatic t_avst_txs tx_clr_valid(input t_avst_txs beat);
        t_avst_txs b;
        b = beat;
        for (int ch = 0; ch < NUM_AVST_CH; ch++) begin
            b[ch].valid = 1'b0;
        end
        return b;
    endfunction

    // Walk channels low to high; within a channel sop is applied before eop,
    // so a channel holding a whole TLP leaves the tracker closed.
    function automatic logic tx_arb_track_pkt(input t_avst_txs beat, input logic start);
        logic in_pkt;
        in_pkt = start;
        for (int ch = 0; ch < NUM_AVST_CH; ch++) begin
            if (beat[ch].valid) begin
                if (beat[ch].sop) in_pkt = 1'b1;
                if (beat[ch].eop) in_pkt = 1'b0;
            end
        end
        return in_pkt;
    endfunction

endpackage

// File: rtl/ofs_fim_rr_pick.sv
// ----------------------------------------------------------------------------
// ofs_fim_rr_pick
// Combinational round-robin picker: returns the first requesting index at or
// after i_ptr (modulo N). Shared by the TX arbiter and RX fan-out scheduling.
// Ports:
//   i_req   [N]      request vector
//   i_ptr   [IDX_W]  search start index (expected < N)
//   o_grant [N]      one-hot winner, 0 when nothing requests
//   o_idx   [IDX_W]  winner index, 0 when nothing requests
//   o_any   1        at least one request present
// ----------------------------------------------------------------------------
module ofs_fim_rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan offsets from the far end down so the nearest request to the
    // pointer is the last one written and therefore wins.
    always_comb begin
        int idx;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(i_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (i_req[idx]) begin
                o_idx = IDX_W'(idx);
                o_any = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_oh
        assign o_grant[gi] = o_any && (o_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/ofs_fim_pcie_tx_arb.sv
// ----------------------------------------------------------------------------
// ofs_fim_pcie_tx_arb
// Packet-atomic round-robin arbiter in front of the PCIe IP AVST TX port.
// A requester that starts a TLP keeps the output until that TLP's EOP has
// been accepted. Output is a single registered beat (1-cycle latency, full
// throughput, no bubble between owners).
//
// Optional feature macro: OFS_FIM_PCIE_TX_ARB_STALL_DET_EN
//   defined   -> stall counter; o_stall_err pulses once when the owner has
//                shown no valid channel for STALL_TIMEOUT-1 locked cycles
//   undefined -> o_stall_err tied to 0
//
// Ports:
//   clk                   clock
//   rst_n                 synchronous active-low reset
//   i_req_tx[NUM_REQ]     per-requester TX beat
//   o_req_ready[NUM_REQ]  per-requester ready (accept = any valid & ready)
//   o_tx                  registered beat to the PCIe IP
//   i_tx_ready            PCIe IP ready for o_tx
//   o_grant[NUM_REQ]      one-hot current owner, 0 when idle
//   o_stall_err           one-cycle owner stall pulse
// ----------------------------------------------------------------------------
module ofs_fim_pcie_tx_arb
    import ofs_fim_pcie_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int STALL_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  t_avst_txs          i_req_tx [NUM_REQ],
    output logic [NUM_REQ-1:0] o_req_ready,
    output t_avst_txs          o_tx,
    input  logic               i_tx_ready,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_stall_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    t_tx_arb_state     r_state;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_rr_ptr;
    t_avst_txs         r_tx;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic [NUM_REQ-1:0] w_sel_oh;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [IDX_W-1:0]   w_next_ptr;
    logic               w_locked;
    logic               w_out_free;
    logic               w_accept;
    logic               w_in_pkt;
    t_avst_txs          w_beat;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_req[gi] = tx_any_valid(i_req_tx[gi]);
    end

    ofs_fim_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_locked   = (r_state == ARB_LOCKED);
    assign w_out_free = ~tx_any_valid(r_tx) | i_tx_ready;
    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    // While locked the owner's ready follows the output stage even if it has
    // nothing valid, so no other requester can sneak into the packet.
    assign w_sel_idx   = w_locked ? r_owner : w_pick_idx;
    assign w_sel_oh    = w_locked ? w_owner_oh : w_pick_oh;
    assign o_req_ready = (rst_n && w_out_free) ? w_sel_oh : '0;
    assign w_accept    = |(o_req_ready & w_req);

    assign w_beat     = i_req_tx[w_sel_idx];
    assign w_in_pkt   = tx_arb_track_pkt(w_beat, w_locked);
    assign w_next_ptr = (w_sel_idx == LAST_IDX) ? '0 : w_sel_idx + 1'b1;

    assign o_grant = w_locked ? w_owner_oh : (w_accept ? w_pick_oh : '0);
    assign o_tx    = r_tx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_tx     <= '0;
        end else begin
            if (w_accept) begin
                r_tx <= w_beat;
                if (w_in_pkt) begin
                    r_state <= ARB_LOCKED;
                    r_owner <= w_sel_idx;
                end else begin
                    // Pointer only moves when a TLP completes, so the next
                    // search starts just past the requester that finished.
                    r_state  <= ARB_IDLE;
                    r_rr_ptr <= w_next_ptr;
                end
            end else if (i_tx_ready) begin
                r_tx <= tx_clr_valid(r_tx);
            end
        end
    end

`ifdef OFS_FIM_PCIE_TX_ARB_STALL_DET_EN
    localparam int CNT_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STALL_TIMEOUT - 2);

    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_stall_err;
    logic             w_stall_cycle;

    assign w_stall_cycle = w_locked && !w_req[r_owner];

    // Counter saturates at CNT_MAX; the pulse is raised only on the step
    // that reaches it, so a long stall produces a single pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_stall_err <= 1'b0;
            if (w_accept || !w_locked) begin
                r_stall_cnt <= '0;
            end else if (w_stall_cycle && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
                if (r_stall_cnt == CNT_PRE) r_stall_err <= 1'b1;
            end
        end
    end

    assign o_stall_err = r_stall_err;
`else
    assign o_stall_err = 1'b0;
`endif

endmodule

// File: doc/ofs_fim_pcie_tx_arb.md
# ofs_fim_pcie_tx_arb

Packet-atomic round-robin arbiter that shares the PCIe IP AVST TX interface (`t_avst_txs`, `NUM_AVST_CH` channels per beat) between `NUM_REQ` TLP sources, such as the MMIO completion path, the host-write path and the interrupt/message path. It sits directly in front of the PCIe IP TX port. Once a requester starts a TLP, it owns the output until that TLP's EOP has passed. The output is registered, with one beat of buffering.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters, 2..`TX_ARB_MAX_REQ`.
- `STALL_TIMEOUT`, default 4096: cycles an owner may present no valid channel mid-packet before a stall error is flagged. Must be ≥ 2.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_req_tx[NUM_REQ]`  in  `t_avst_txs`  per-requester TX beat (`valid`/`sop`/`eop`/`hdr`/`data`/`vf_active` per channel).
- `o_req_ready[NUM_REQ]`  out  1  beat of requester i is accepted when any channel is valid and ready is 1.
- `o_tx`  out  `t_avst_txs`  registered beat to the PCIe IP.
- `i_tx_ready`  in  1  the PCIe IP accepts `o_tx` when any `o_tx[ch].valid` is 1 and this is 1.
- `o_grant`  out  `NUM_REQ`  one-hot current owner; 0 when idle.
- `o_stall_err`  out  1  one-cycle pulse on owner stall (see Configuration).

## Operation
- Request for requester i: any `i_req_tx[i][ch].valid`.
- Output stage free: `~|o_tx[*].valid | i_tx_ready`.
- The state machine has two states, `ARB_IDLE` and `ARB_LOCKED`. It also holds an `owner` index and a round-robin pointer `rr_ptr`.
- `ARB_IDLE` behaviour:
  - Winner is the first requesting index at or after `rr_ptr`, modulo `NUM_REQ`, chosen combinationally.
  - `o_req_ready[winner]` = output stage free. All other readies are 0.
- `ARB_LOCKED` behaviour:
  - Only `o_req_ready[owner]` may be 1, equal to output stage free.
  - Other requests are ignored, even when the owner has nothing valid.
- Packet tracking on each accepted beat: scan the channels from 0 to `NUM_AVST_CH-1`.
  - A valid channel with `sop` sets in_pkt.
  - A valid channel with `eop` clears in_pkt. When one channel has both, `sop` is applied before `eop`.
  - Starting value: 0 in IDLE, 1 in LOCKED.
- Transitions on an accepted beat:
  - If final in_pkt = 1: go to, or stay in, LOCKED with `owner` = accepting requester.
  - If final in_pkt = 0: go to IDLE and set `rr_ptr` = (accepting index + 1) mod `NUM_REQ`.
- A single-beat TLP never enters LOCKED. `rr_ptr` still advances.
- An EOP on ch0 followed by an SOP on ch1 in the same beat keeps the same owner locked for the new TLP.
- A beat without `sop` accepted in IDLE is passed through unchanged. The tracking rules still apply, so no lock is taken unless an `sop` appears.
- `o_grant` = one-hot of `owner` in LOCKED, and of `winner` in IDLE while an accept occurs; 0 otherwise.
- Output register:
  - On accept, `o_tx` is loaded with the accepted beat.
  - Else if `i_tx_ready` is 1, all `o_tx[*].valid` are cleared.
  - Otherwise `o_tx` holds every bit stable.

## Timing
- Latency is 1 cycle from accepted input beat to `o_tx`.
- Full throughput: one beat per cycle while `i_tx_ready` = 1.
- Back-to-back packets from different requesters carry no idle bubble.
- Reset values:
  - `o_tx` all zero.
  - `o_req_ready` all 0. Readies are forced to 0 while `rst_n` = 0.
  - `o_grant` = 0, `o_stall_err` = 0.
  - State `ARB_IDLE`, `rr_ptr` = 0, stall counter = 0.
- Reset mid-packet: the lock is discarded and `o_tx` is cleared on the next clock. Any partial TLP is the source's responsibility.
- `i_tx_ready` low with a valid `o_tx`: all readies are 0 and `o_tx` is held.
- Wrap-around: `rr_ptr` = `NUM_REQ-1` with an accept moves to 0.

## Configuration
- `OFS_FIM_PCIE_TX_ARB_STALL_DET_EN` defined:
  - A counter runs while in LOCKED with the owner presenting no valid channel. It is cleared on any accepted beat and on leaving LOCKED.
  - When it reaches `STALL_TIMEOUT-1`, `o_stall_err` pulses for one cycle and the counter saturates. No further pulse is raised until it is cleared.
  - The lock is held; there is no forced release.
- Macro undefined: no counter; `o_stall_err` is tied to 0.

## Structure
- Shared package `ofs_fim_pcie_pkg` holds:
  - `localparam TX_ARB_MAX_REQ = 8`;
  - `typedef enum logic {ARB_IDLE, ARB_LOCKED} t_tx_arb_state`.
- Sub-module `ofs_fim_rr_pick`: combinational round-robin picker over a request vector and a pointer. It outputs a one-hot grant and the winner index. It is reusable for RX fan-out scheduling.

## Test plan
- Requesters 0 and 2 each present one single-beat TLP (ch0 `sop`+`eop`) simultaneously from reset -> `o_tx` shows req0's beat at cycle 1 and req2's beat at cycle 2; `rr_ptr` ends at 0.
- Req1 sends a 3-beat TLP while req0 continuously requests -> req0 readies stay 0 for all 3 beats; req0 is granted in the cycle after req1's EOP beat is accepted.
- Req0 beat has ch0 `eop` and ch1 `sop`, followed by an EOP beat -> req0 stays locked across both; req1 is granted only after the second beat.
- `i_tx_ready` held low for 5 cycles mid-packet -> `o_tx` is bit-stable and all readies are 0; transfer resumes with no lost or duplicated beats.
- With the macro defined and `STALL_TIMEOUT`=16: owner withholds valid for 20 cycles mid-packet -> exactly one `o_stall_err` pulse at idle cycle 16, and the lock is held. With the macro undefined, `o_stall_err` stays 0.
- `rst_n` asserted during the 2nd beat of a 4-beat TLP -> next cycle: `o_tx` all zero, `o_grant` = 0, and the next request is granted starting from index 0.
